// File: rtl/sevenseg_capture.sv
// sevenseg_capture: reading end of the multiplexed 4-digit seven-segment bus.
// Waits for each digit's drive to settle, decodes it back to a hex nibble,
// assembles complete scan frames and publishes the value once the same frame
// has been seen STABLE_SCANS times in a row.
//
// Bus handshake: there is no valid/ready pair on the input side; a digit is
// "offered" by holding one anode low with a constant segment pattern, and it
// is "accepted" (sampled) once it has been stable for SETTLE cycles. On the
// output side `valid` is a one-cycle strobe with no back-pressure.
module sevenseg_capture #(
  parameter int SETTLE       = 4,
  parameter int STABLE_SCANS = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sevenseg,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        valid,
  output logic        err,
  output logic        locked,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_WAIT = 2'd0, S_SETTLE = 2'd1, S_HELD = 2'd2} state_t;

  localparam logic [7:0]  SETTLE_C = 8'(SETTLE);
  localparam logic [3:0]  SS_M1    = 4'(STABLE_SCANS - 1);
  localparam logic [15:0] TO_C     = 16'(TIMEOUT);
  localparam logic [15:0] TO_M1    = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  an_p_q;
  logic [6:0]  seg_p_q;
  logic [15:0] slot_dig_q, slot_dig_d;
  logic [3:0]  slot_blk_q, slot_blk_d;
  logic [3:0]  filled_q, filled_d;
  logic [15:0] last_dig_q, last_dig_d;
  logic [3:0]  last_blk_q, last_blk_d;
  logic        last_vld_q, last_vld_d;
  logic [3:0]  match_q, match_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  blank_q, blank_d;
  logic        valid_q, valid_d, err_q, err_d, locked_q, locked_d;

  logic [6:0] abc;
  logic [3:0] dec_nib;
  logic       dec_blk, dec_bad;
  logic [3:0] low;
  logic       one_hot;
  logic [1:0] idx;
  logic       an_chg, seg_chg, eval, take, multi_err;

  // Segment decode; abc lists segments a..g from MSB to LSB
  always_comb begin
    abc     = {sevenseg[0], sevenseg[1], sevenseg[2], sevenseg[3],
               sevenseg[4], sevenseg[5], sevenseg[6]};
    dec_nib = 4'h0;
    dec_blk = 1'b0;
    dec_bad = 1'b0;
    case (abc)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      7'b1111111: dec_blk = 1'b1;
      default:    dec_bad = 1'b1;
    endcase
  end

  // Anode classification against the previous cycle's bus
  always_comb begin
    low     = ~anode;
    one_hot = (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
    an_chg  = (anode != an_p_q);
    seg_chg = (sevenseg != seg_p_q);
    case (low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Dwell FSM: settle counting and the single sample per dwell
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eval      = 1'b0;
    take      = 1'b0;
    multi_err = 1'b0;
    case (state_q)
      S_WAIT:   eval = 1'b1;
      S_SETTLE: begin
        if (an_chg || seg_chg) begin
          eval = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == SETTLE_C) begin
            take    = 1'b1;
            state_d = S_HELD;
          end
        end
      end
      S_HELD:   eval = an_chg;
      default:  state_d = S_WAIT;
    endcase
    if (eval) begin
      if (anode == 4'hF) begin
        state_d = S_WAIT;
      end else if (one_hot) begin
        cnt_d = 8'd1;
        if (SETTLE_C == 8'd1) begin
          take    = 1'b1;
          state_d = S_HELD;
        end else begin
          state_d = S_SETTLE;
        end
      end else begin
        // A held multi-anode pattern reports once, on its arrival
        state_d   = S_WAIT;
        multi_err = (state_q != S_WAIT) || an_chg;
      end
    end
  end

  // Frame assembly, stability matching, publish, error and timeout handling
  always_comb begin
    logic        err_evt, to_evt, complete, same_last, differs;
    logic [3:0]  match_new;
    slot_dig_d = slot_dig_q;
    slot_blk_d = slot_blk_q;
    filled_d   = filled_q;
    last_dig_d = last_dig_q;
    last_blk_d = last_blk_q;
    last_vld_d = last_vld_q;
    match_d    = match_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    err_evt    = multi_err | (take & dec_bad);
    to_evt     = !take && (idle_q == TO_M1);
    complete   = (filled_q == 4'hF);
    err_d      = err_evt;

    if (take) idle_d = 16'h0000;
    else if (idle_q != TO_C) idle_d = idle_q + 16'd1;
    else idle_d = idle_q;

    if (complete) filled_d = 4'h0;
    if (take && !dec_bad) begin
      slot_dig_d[idx*4 +: 4] = dec_nib;
      slot_blk_d[idx]        = dec_blk;
      filled_d[idx]          = 1'b1;
    end

    same_last = last_vld_q && (slot_dig_q == last_dig_q) && (slot_blk_q == last_blk_q);
    match_new = same_last ? ((match_q == 4'hF) ? 4'hF : match_q + 4'd1) : 4'h0;
    differs   = (slot_dig_q != digits_q) || (slot_blk_q != blank_q);

    if (err_evt || to_evt) begin
      filled_d   = 4'h0;
      match_d    = 4'h0;
      last_vld_d = 1'b0;
      locked_d   = 1'b0;
    end else if (complete) begin
      last_dig_d = slot_dig_q;
      last_blk_d = slot_blk_q;
      last_vld_d = 1'b1;
      match_d    = match_new;
      if ((match_new >= SS_M1) && (differs || !locked_q)) begin
        digits_d = slot_dig_q;
        blank_d  = slot_blk_q;
        valid_d  = 1'b1;
        locked_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_WAIT;
      cnt_q      <= 8'd0;
      an_p_q     <= 4'hF;
      seg_p_q    <= 7'h7F;
      slot_dig_q <= 16'h0000;
      slot_blk_q <= 4'h0;
      filled_q   <= 4'h0;
      last_dig_q <= 16'h0000;
      last_blk_q <= 4'h0;
      last_vld_q <= 1'b0;
      match_q    <= 4'h0;
      idle_q     <= 16'h0000;
      digits_q   <= 16'h0000;
      blank_q    <= 4'hF;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      an_p_q     <= anode;
      seg_p_q    <= sevenseg;
      slot_dig_q <= slot_dig_d;
      slot_blk_q <= slot_blk_d;
      filled_q   <= filled_d;
      last_dig_q <= last_dig_d;
      last_blk_q <= last_blk_d;
      last_vld_q <= last_vld_d;
      match_q    <= match_d;
      idle_q     <= idle_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign digits    = digits_q;
  assign blank     = blank_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign locked    = locked_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: table of whole-scan vectors plus hand-written
// sequences for decode error, multi-anode error, timeout and mid-frame reset.
module tb_sevenseg_capture;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  sevenseg = 7'h7F;
  logic [3:0]  anode = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        valid, err, locked;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Segment patterns in a..g order (MSB = a), hand-copied from the decode table
  logic [6:0] seg_tab [16];

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  blk;
    int          dwell;
    int          frames;
    int          exp_valid;
    logic [15:0] exp_digits;
    logic [3:0]  exp_blank;
    logic        exp_locked;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  sevenseg_capture #(.SETTLE(4), .STABLE_SCANS(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sevenseg(sevenseg), .anode(anode),
    .digits(digits), .blank(blank), .valid(valid), .err(err),
    .locked(locked), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (rst && valid) valid_cnt++;
    if (rst && err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one digit with a pattern given in a..g order for cyc cycles
  task automatic dwell_one(input int d, input logic [6:0] p, input int cyc);
    logic [6:0] bus;
    for (int i = 0; i < 7; i++) bus[i] = p[6-i];
    anode    = ~(4'b0001 << d);
    sevenseg = bus;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] dig, input logic [3:0] blk, input int dwell,
                      input int start, input int ndig);
    for (int k = 0; k < ndig; k++) begin
      int d;
      d = (start + k) % 4;
      dwell_one(d, blk[d] ? 7'b1111111 : seg_tab[dig[d*4 +: 4]], dwell);
    end
  endtask

  task automatic idle(input int cyc);
    anode    = 4'hF;
    sevenseg = 7'h7F;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [15:0] d, input logic [3:0] b,
                           input logic l);
    check({tag, " digits"}, 32'(digits), 32'(d));
    check({tag, " blank"},  32'(blank),  32'(b));
    check({tag, " locked"}, 32'(locked), 32'(l));
  endtask

  initial begin
    int v0, e0;
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    //          dig       blk      dw fr  val  exp_dig   exp_blk  lock
    vecs[0] = '{16'h1234, 4'h0,    8, 1,  0,   16'h0000, 4'hF,    1'b0};
    vecs[1] = '{16'h1234, 4'h0,    8, 1,  1,   16'h1234, 4'h0,    1'b1};
    vecs[2] = '{16'h1234, 4'h0,    8, 2,  0,   16'h1234, 4'h0,    1'b1};
    vecs[3] = '{16'h00F0, 4'h0,    8, 2,  1,   16'h00F0, 4'h0,    1'b1};
    vecs[4] = '{16'h7077, 4'b0100, 8, 2,  1,   16'h7077, 4'b0100, 1'b1};
    vecs[5] = '{16'h4321, 4'h0,    4, 2,  1,   16'h4321, 4'h0,    1'b1};
    vecs[6] = '{16'h9999, 4'h0,    3, 3,  0,   16'h4321, 4'h0,    1'b1};
    vecs[7] = '{16'hCAFE, 4'h0,    8, 2,  1,   16'hCAFE, 4'h0,    1'b1};
    vecs[8] = '{16'h5689, 4'h0,    5, 3,  1,   16'h5689, 4'h0,    1'b1};
    vecs[9] = '{16'hBD00, 4'h0,    8, 2,  1,   16'hBD00, 4'h0,    1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check_out("reset", 16'h0000, 4'hF, 1'b0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table of whole-scan vectors
    for (int i = 0; i < NV; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      scan(vecs[i].dig, vecs[i].blk, vecs[i].dwell, 0, 4 * vecs[i].frames);
      idle(3);
      check($sformatf("v%0d valid count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d err count", i), 32'(err_cnt - e0), 32'd0);
      check_out($sformatf("v%0d", i), vecs[i].exp_digits, vecs[i].exp_blank, vecs[i].exp_locked);
    end

    // Decode error on digit 1, then recovery
    v0 = valid_cnt;
    e0 = err_cnt;
    scan(16'h00F0, 4'h0, 8, 0, 1);
    dwell_one(1, 7'b1111110, 8);
    check("decerr err count", 32'(err_cnt - e0), 32'd1);
    check_out("decerr", 16'hBD00, 4'h0, 1'b0);
    scan(16'h00F0, 4'h0, 8, 2, 2);
    scan(16'h00F0, 4'h0, 8, 0, 8);
    idle(3);
    check("recover valid count", 32'(valid_cnt - v0), 32'd1);
    check_out("recover", 16'h00F0, 4'h0, 1'b1);

    // Multi-anode error
    e0 = err_cnt;
    anode    = 4'b1100;
    sevenseg = 7'h00;
    repeat (5) @(negedge clk);
    idle(3);
    check("multi err count", 32'(err_cnt - e0), 32'd1);
    check("multi locked", 32'(locked), 32'd0);
    check("multi digits", 32'(digits), 32'h00F0);

    // Relock, then short dwells until timeout
    v0 = valid_cnt;
    scan(16'h00F0, 4'h0, 8, 0, 8);
    check("relock valid count", 32'(valid_cnt - v0), 32'd1);
    e0 = err_cnt;
    v0 = valid_cnt;
    scan(16'h1111, 4'h0, 3, 0, 33);
    check("pre-timeout locked", 32'(locked), 32'd1);
    scan(16'h1111, 4'h0, 3, 1, 40);
    check("timeout locked", 32'(locked), 32'd0);
    check("timeout err count", 32'(err_cnt - e0), 32'd0);
    check("timeout valid count", 32'(valid_cnt - v0), 32'd0);
    check("timeout digits", 32'(digits), 32'h00F0);

    // Reset in the middle of the second frame
    scan(16'h1234, 4'h0, 8, 0, 6);
    rst = 1'b0;
    #1;
    check_out("midrst", 16'h0000, 4'hF, 1'b0);
    check("midrst valid", 32'(valid), 32'd0);
    anode = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    v0 = valid_cnt;
    scan(16'h1234, 4'h0, 8, 0, 4);
    idle(3);
    check("post-rst frame1 valid count", 32'(valid_cnt - v0), 32'd0);
    check("post-rst frame1 locked", 32'(locked), 32'd0);
    scan(16'h1234, 4'h0, 8, 0, 4);
    idle(3);
    check("post-rst frame2 valid count", 32'(valid_cnt - v0), 32'd1);
    check_out("post-rst", 16'h1234, 4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receiver for the multiplexed 4-digit seven-segment bus driven by the ALU display path. It watches `sevenseg`/`anode`, waits for each digit's drive to settle, decodes the segment pattern back to a hex nibble, and assembles complete scan frames. After `STABLE_SCANS` identical frames it publishes the 16-bit displayed value with a one-cycle `valid` strobe. It sits in benches and on-chip self-check logic as the reading end of the display interface.

## Interface
- `SETTLE`, default 4: consecutive cycles of unchanged `anode`+`sevenseg` required before a digit is sampled (1..255).
- `STABLE_SCANS`, default 2: consecutive identical complete frames required to publish (1..15).
- `TIMEOUT`, default 4096: cycles without any sample before `locked` drops (2..65535).

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sevenseg` in [0:6]: segments a..g, active-low; `sevenseg[0]`=a, `sevenseg[6]`=g.
- `anode` in 4: digit enables, active-low one-hot; `anode[0]` = digit 0 = `digits[3:0]`.
- `digits` out 16: last published value, nibble i = digit i.
- `blank` out 4: bit i = digit i was all-segments-off in the published frame.
- `valid` out 1: one-cycle pulse when `digits`/`blank` are updated.
- `err` out 1: one-cycle pulse on a protocol or decode error.
- `locked` out 1: a frame has been published and there has been no error/timeout since.

## Operation
- Reset values: `digits`=16'h0000, `blank`=4'hF, `valid`=0, `err`=0, `locked`=0, FSM=WAIT, filled mask=0, match count=0.
- Decode, `sevenseg[0:6]`: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - 1111111 = blank: nibble 0, blank bit set.
  - Any other pattern = decode error.
- FSM:
  - WAIT: `anode`=4'hF (idle), stays. Exactly one bit low → SETTLE, counter=1. More than one bit low → `err`, discard frame, stays in WAIT.
  - SETTLE: `anode` or `sevenseg` changes → counter=1, re-evaluating the new `anode` as in WAIT. Counter reaches `SETTLE` → sample into the slot for the active digit, set filled bit, → HELD.
  - HELD: leaves only when `anode` changes (same rules as WAIT). A segment change while the same anode is held is ignored. Exactly one sample is taken per dwell.
- A sample into an already-filled slot overwrites that slot.
- Frame complete when filled mask = 4'hF, evaluated in the cycle after the 4th sample. On completion the mask clears.
  - Frame equal to `last_frame`: match count increments, saturating.
  - Frame differs: `last_frame`=frame, match count=0.
  - Publish when match count ≥ `STABLE_SCANS`-1 and (frame differs from `digits`/`blank`, or `locked`=0). Publishing loads `digits`/`blank`, pulses `valid`, sets `locked`.
- Error (decode or multi-anode):
  - `err` pulse; clear filled mask and match count; `locked`=0.
  - `digits` retain their old value.
- Timeout: idle counter resets on every sample. Reaching `TIMEOUT` clears `locked`, filled mask and match count. No `err` pulse.
- Simultaneous error and frame completion: the error wins and nothing is published.

## Timing
- Sample occurs on the edge where the settle counter reaches `SETTLE`, i.e. `SETTLE` cycles after the first cycle of a new anode.
- `valid`/`digits` update 1 cycle after the completing sample. `valid` is high exactly 1 cycle.
- `err` is asserted in the cycle after the offending input is registered.
- Dwells shorter than `SETTLE` cycles are never sampled.
- Asserting reset mid-operation returns all outputs to reset values immediately; the first publish after release needs `STABLE_SCANS` full frames again.
- Inputs are synchronous to `clk`; no internal synchronizer.

## Test plan
- Scan "1234" (digit0=4, 1=3, 2=2, 3=1), 8-cycle dwell, `SETTLE`=4, `STABLE_SCANS`=2 → one `valid` after the 2nd frame, `digits`=16'h1234, `blank`=0, `locked`=1. No further `valid` while the scan is unchanged.
- Switch the scan to "00F0" mid-stream → `valid` after 2 full new frames, `digits`=16'h00F0. No intermediate publish of a mixed frame.
- Drive digit 2 as 1111111, others "7" → `digits`=16'h7077, `blank`=4'b0100.
- Pattern 1111110 on digit1 → `err` pulse, `locked`=0, `digits` unchanged. Recovers after 2 clean frames.
- `anode`=4'b1100 → `err`. 3-cycle dwells with `SETTLE`=4 → no samples; `TIMEOUT` cycles later `locked`=0, no `err`.
- Pull `rst` low in the middle of the 2nd frame → outputs at reset values. After release, publish needs 2 fresh frames.
